// File: rtl/pipeline_stall_flush_ctrl.sv
// Stall/flush/redirect controller for the 5-stage RV32I pipeline.
// It also holds the post-redirect IF_ID flush window, a load-stall watchdog and saturating perf counters.
module pipeline_stall_flush_ctrl #(
    parameter int FLUSH_PENALTY = 1,
    parameter int STALL_TIMEOUT = 16,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_stall_req,
    input  logic             mispredict_EX,
    input  logic             mem_busy,
    output logic             PC_write,
    output logic             IF_ID_write_en,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             EX_MEM_write_en,
    output logic             pc_redirect,
    output logic             hazard_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);
    localparam int WD_W = $clog2(STALL_TIMEOUT + 1);

    typedef enum logic {RUN, REDIRECT} state_t;

    state_t           state_q, state_d;
    logic [2:0]       pen_q, pen_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             to_q, to_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic take_mp, take_ls;
    assign take_mp = mispredict_EX & ~mem_busy;
    assign take_ls = load_stall_req & ~mem_busy & ~mispredict_EX;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pen_q   <= '0;
            wd_q    <= '0;
            to_q    <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            pen_q   <= pen_d;
            wd_q    <= wd_d;
            to_q    <= to_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pen_d   = pen_q;
        wd_d    = wd_q;
        stall_d = stall_q;
        flush_d = flush_q;

        // A freeze holds the window; a load stall still burns penalty cycles.
        if (take_mp) begin
            if (FLUSH_PENALTY > 0) begin
                state_d = REDIRECT;
                pen_d   = 3'(FLUSH_PENALTY);
            end
        end else if (!mem_busy && state_q == REDIRECT) begin
            pen_d = pen_q - 3'd1;
            if (pen_q <= 3'd1) state_d = RUN;
        end

        if (!load_stall_req)
            wd_d = '0;
        else if (!mem_busy && wd_q != WD_W'(STALL_TIMEOUT))
            wd_d = wd_q + 1'b1;
        to_d = to_q | (wd_d == WD_W'(STALL_TIMEOUT));

        if ((mem_busy || take_ls) && stall_q != '1) stall_d = stall_q + 1'b1;
        if (take_mp && flush_q != '1) flush_d = flush_q + 1'b1;
    end

    always_comb begin
        PC_write        = 1'b1;
        IF_ID_write_en  = 1'b1;
        IF_ID_flush     = 1'b0;
        ID_EX_flush     = 1'b0;
        EX_MEM_write_en = 1'b1;
        pc_redirect     = 1'b0;
        if (!rst_n) begin
            PC_write        = 1'b0;
            IF_ID_write_en  = 1'b0;
            IF_ID_flush     = 1'b1;
            ID_EX_flush     = 1'b1;
            EX_MEM_write_en = 1'b0;
        end else if (mem_busy) begin
            PC_write        = 1'b0;
            IF_ID_write_en  = 1'b0;
            EX_MEM_write_en = 1'b0;
        end else if (mispredict_EX) begin
            pc_redirect = 1'b1;
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (load_stall_req) begin
            PC_write       = 1'b0;
            IF_ID_write_en = 1'b0;
            ID_EX_flush    = 1'b1;
            IF_ID_flush    = (state_q == REDIRECT);
        end else if (state_q == REDIRECT) begin
            IF_ID_flush = 1'b1;
        end
    end

    assign hazard_timeout = to_q;
    assign stall_cycles   = stall_q;
    assign flush_events   = flush_q;

endmodule

// File: tb/tb_pipeline_stall_flush_ctrl.sv
// Directed-vector bench: each stimulus cycle queues its expected outputs; a negedge monitor pops and compares.
module tb_pipeline_stall_flush_ctrl;
    localparam int CNT_W = 5;

    // {PC_write, IF_ID_write_en, IF_ID_flush, ID_EX_flush, EX_MEM_write_en, pc_redirect}
    localparam logic [5:0] RST    = 6'b001100;
    localparam logic [5:0] IDLE   = 6'b110010;
    localparam logic [5:0] LS_RUN = 6'b000110;
    localparam logic [5:0] LS_RED = 6'b001110;
    localparam logic [5:0] MISP   = 6'b111111;
    localparam logic [5:0] REDW   = 6'b111010;
    localparam logic [5:0] BUSY   = 6'b000000;

    typedef struct {
        int         idx;
        logic [5:0] o;
        int         s;
        int         f;
        logic       t;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_stall_req = 1'b0, mispredict_EX = 1'b0, mem_busy = 1'b0;
    logic PC_write, IF_ID_write_en, IF_ID_flush, ID_EX_flush, EX_MEM_write_en, pc_redirect;
    logic hazard_timeout;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    exp_t q[$];
    int n_chk = 0;
    int n_fail = 0;
    int vec = 0;

    always #5 clk = ~clk;

    pipeline_stall_flush_ctrl #(.FLUSH_PENALTY(1), .STALL_TIMEOUT(16), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_stall_req(load_stall_req), .mispredict_EX(mispredict_EX), .mem_busy(mem_busy),
        .PC_write(PC_write), .IF_ID_write_en(IF_ID_write_en), .IF_ID_flush(IF_ID_flush),
        .ID_EX_flush(ID_EX_flush), .EX_MEM_write_en(EX_MEM_write_en), .pc_redirect(pc_redirect),
        .hazard_timeout(hazard_timeout), .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    task automatic check(input string nm, input int idx, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got 0x%0h want 0x%0h", nm, idx, act, exp);
        end
    endtask

    task automatic step(input bit rst, input bit ls, input bit mp, input bit mb,
                        input logic [5:0] o, input int s, input int f, input bit t);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n          = !rst;
        load_stall_req = ls;
        mispredict_EX  = mp;
        mem_busy       = mb;
        e.idx = vec; e.o = o; e.s = s; e.f = f; e.t = t;
        q.push_back(e);
        vec++;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [5:0] act;
            e = q.pop_front();
            act = {PC_write, IF_ID_write_en, IF_ID_flush, ID_EX_flush, EX_MEM_write_en, pc_redirect};
            check("ctrl", e.idx, int'(act), int'(e.o));
            check("stall_cycles", e.idx, int'(stall_cycles), e.s);
            check("flush_events", e.idx, int'(flush_events), e.f);
            check("hazard_timeout", e.idx, int'(hazard_timeout), int'(e.t));
        end
    end

    initial begin
        step(1, 0, 0, 0, RST, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, IDLE, 0, 0, 0);
        // single load stall
        step(0, 1, 0, 0, LS_RUN, 0, 0, 0);
        step(0, 0, 0, 0, IDLE, 1, 0, 0);
        // mispredict with one-cycle penalty window
        step(0, 0, 1, 0, MISP, 1, 0, 0);
        step(0, 0, 0, 0, REDW, 1, 1, 0);
        step(0, 0, 0, 0, IDLE, 1, 1, 0);
        // mispredict beats concurrent load stall
        step(0, 1, 1, 0, MISP, 1, 1, 0);
        step(0, 0, 0, 0, REDW, 1, 2, 0);
        step(0, 0, 0, 0, IDLE, 1, 2, 0);
        // freeze during REDIRECT with mispredict held
        step(0, 0, 1, 0, MISP, 1, 2, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, BUSY, 1 + i, 3, 0);
        step(0, 0, 1, 0, MISP, 4, 3, 0);
        step(0, 0, 0, 0, REDW, 4, 4, 0);
        step(0, 0, 0, 0, IDLE, 4, 4, 0);
        // load stall inside REDIRECT keeps IF_ID flushed and consumes the window
        step(0, 0, 1, 0, MISP, 4, 4, 0);
        step(0, 1, 0, 0, LS_RED, 4, 5, 0);
        step(0, 0, 0, 0, IDLE, 5, 5, 0);
        // watchdog: 16 counted stall cycles, freeze in the middle does not count
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, LS_RUN, 5 + i, 5, 0);
        for (int i = 0; i < 2; i++) step(0, 1, 0, 1, BUSY, 13 + i, 5, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, LS_RUN, 15 + i, 5, 0);
        step(0, 0, 0, 0, IDLE, 23, 5, 1);
        step(0, 0, 0, 0, IDLE, 23, 5, 1);
        // stall counter saturates at 31
        for (int k = 0; k < 10; k++) step(0, 1, 0, 0, LS_RUN, (23 + k > 31) ? 31 : 23 + k, 5, 1);
        step(0, 0, 0, 0, IDLE, 31, 5, 1);
        // reset mid-REDIRECT aborts the window
        step(0, 0, 1, 0, MISP, 31, 5, 1);
        step(1, 0, 0, 0, RST, 0, 0, 0);
        step(0, 0, 0, 0, IDLE, 0, 0, 0);
        step(0, 0, 0, 0, IDLE, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        check("queue_drained", vec, q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
